// File: rtl/mem_access_ctrl.sv
// Access sequencer for the unified 64x16 instruction/data memory.
// Arbitrates fetch vs. load/store requests, latches IR/MDR and parks in HALT on the END word.
module mem_access_ctrl #(
    parameter int          DEPTH     = 64,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [15:0] pc,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    input  logic [15:0] mem_rd,
    output logic [15:0] mem_a,
    output logic [15:0] mem_wd,
    output logic        mem_we,
    output logic        req_ack,
    output logic [15:0] ir,
    output logic        instr_valid,
    output logic [15:0] mdr,
    output logic        data_done,
    output logic        addr_err,
    output logic        busy,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    // Handshake: a requester holds its req (and operands) high until it sees
    // req_ack in the same cycle; the operands are captured on that clock edge.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DATA_RD = 3'd2,
        DATA_WR = 3'd3,
        DONE    = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic        in_range;

    assign in_range = (addr_reg < DEPTH_W);
    assign mem_a    = addr_reg;
    assign mem_wd   = wdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_req) begin
                    state_next = data_we ? DATA_WR : DATA_RD;
                end else if (fetch_req) begin
                    state_next = FETCH;
                end
            end
            FETCH:   state_next = (mem_rd == HALT_WORD) ? HALT : DONE;
            DATA_RD: state_next = DONE;
            DATA_WR: state_next = DONE;
            DONE:    state_next = IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ack = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b1;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                req_ack = data_req || fetch_req;
            end
            DATA_WR: mem_we = !reset && in_range;
            default: ;
        endcase
    end

    // Pulses are registered off the access state so they line up with the DONE/HALT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg    <= 16'h0000;
            wdata_reg   <= 16'h0000;
            ir          <= 16'h0000;
            mdr         <= 16'h0000;
            fetch_cnt   <= 16'h0000;
            instr_valid <= 1'b0;
            data_done   <= 1'b0;
            addr_err    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            data_done   <= 1'b0;
            addr_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req) begin
                        addr_reg  <= data_addr;
                        wdata_reg <= data_wdata;
                    end else if (fetch_req) begin
                        addr_reg <= pc;
                    end
                end
                FETCH: begin
                    instr_valid <= 1'b1;
                    addr_err    <= !in_range;
                    if (in_range) begin
                        ir <= mem_rd;
                        if (fetch_cnt != 16'hFFFF) begin
                            fetch_cnt <= fetch_cnt + 16'd1;
                        end
                    end
                    if (mem_rd == HALT_WORD) begin
                        halted <= 1'b1;
                    end
                end
                DATA_RD: begin
                    data_done <= 1'b1;
                    addr_err  <= !in_range;
                    if (in_range) begin
                        mdr <= mem_rd;
                    end
                end
                DATA_WR: begin
                    data_done <= 1'b1;
                    addr_err  <= !in_range;
                end
                default: ;
            endcase
        end
    end

endmodule
